// File: rtl/gaussian_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : gaussian_pkg
// Brief   : Shared state encoding and accumulator width helpers.
// Revision: 1.0
// ---------------------------------------------------------------------------
package gaussian_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    CALC1 = 3'd2,
    CALC2 = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Wide enough that a full window of most-negative samples cannot overflow.
  function automatic int sum_w(input int in_width, input int log2_n);
    return in_width + log2_n;
  endfunction

  function automatic int sq_w(input int in_width, input int log2_n);
    return 2 * in_width + log2_n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/moment_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : moment_accumulator
// Brief   : Running sum, sum of squares, min, max and sample count.
// Revision: 1.0
// ---------------------------------------------------------------------------
module moment_accumulator
  import gaussian_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int LOG2_N   = 10
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     clear,
  input  logic                                     enable,
  input  logic signed [IN_WIDTH-1:0]               sample,
  input  logic        [2*IN_WIDTH-1:0]             sample_sq,
  output logic signed [sum_w(IN_WIDTH, LOG2_N)-1:0] sum,
  output logic        [sq_w(IN_WIDTH, LOG2_N)-1:0]  sumsq,
  output logic signed [IN_WIDTH-1:0]               min_val,
  output logic signed [IN_WIDTH-1:0]               max_val,
  output logic                                     last
);

  localparam int SUM_W = sum_w(IN_WIDTH, LOG2_N);
  localparam int SQ_W  = sq_w(IN_WIDTH, LOG2_N);
  localparam int CW    = LOG2_N + 1;
  localparam logic [CW-1:0] C_LAST = CW'((1 << LOG2_N) - 1);
  localparam logic signed [IN_WIDTH-1:0] C_POS_MAX = {1'b0, {(IN_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] C_NEG_MAX = {1'b1, {(IN_WIDTH-1){1'b0}}};

  logic signed [SUM_W-1:0]    r_sum;
  logic        [SQ_W-1:0]     r_sumsq;
  logic signed [IN_WIDTH-1:0] r_min;
  logic signed [IN_WIDTH-1:0] r_max;
  logic        [CW-1:0]       r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_sumsq <= '0;
      r_min   <= '0;
      r_max   <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_sum   <= '0;
      r_sumsq <= '0;
      r_min   <= C_POS_MAX;
      r_max   <= C_NEG_MAX;
      r_count <= '0;
    end else if (enable) begin
      r_sum   <= r_sum + SUM_W'(sample);
      r_sumsq <= r_sumsq + SQ_W'(sample_sq);
      if (sample < r_min) r_min <= sample;
      if (sample > r_max) r_max <= sample;
      r_count <= r_count + 1'b1;
    end
  end

  assign sum     = r_sum;
  assign sumsq   = r_sumsq;
  assign min_val = r_min;
  assign max_val = r_max;
  assign last    = enable && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/gaussian_stats_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : gaussian_stats_checker
// Brief   : Windowed mean/variance/min/max qualifier for a signed sample stream.
// Revision: 1.0
// ---------------------------------------------------------------------------
module gaussian_stats_checker
  import gaussian_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int LOG2_N   = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic signed [IN_WIDTH-1:0] in_data,
  output logic                       in_ready,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [IN_WIDTH-1:0] mean,
  output logic [2*IN_WIDTH-1:0]      variance,
  output logic signed [IN_WIDTH-1:0] min_val,
  output logic signed [IN_WIDTH-1:0] max_val
);

  localparam int SUM_W = sum_w(IN_WIDTH, LOG2_N);
  localparam int SQ_W  = sq_w(IN_WIDTH, LOG2_N);
  localparam int PW    = 2 * IN_WIDTH;

  state_t r_state;
  state_t w_next;

  logic signed [IN_WIDTH-1:0] w_mul_a;
  logic signed [PW-1:0]       w_prod;
  logic        [PW-1:0]       w_sq;
  logic                       w_clear;
  logic                       w_accept;
  logic                       w_last;
  logic signed [SUM_W-1:0]    w_sum;
  logic        [SQ_W-1:0]     w_sumsq;
  logic signed [IN_WIDTH-1:0] w_min;
  logic signed [IN_WIDTH-1:0] w_max;

  logic signed [IN_WIDTH-1:0] r_mean;
  logic        [PW-1:0]       r_ex2;
  logic        [PW-1:0]       r_var;
  logic signed [IN_WIDTH-1:0] r_min;
  logic signed [IN_WIDTH-1:0] r_max;

  // One shared squarer: samples while accumulating, the mean during CALC2.
  assign w_mul_a = (r_state == CALC2) ? r_mean : in_data;
  assign w_prod  = PW'(w_mul_a) * PW'(w_mul_a);
  assign w_sq    = $unsigned(w_prod);

  assign w_clear  = (r_state == IDLE) && start;
  assign w_accept = (r_state == ACCUM) && in_valid;

  moment_accumulator #(
    .IN_WIDTH (IN_WIDTH),
    .LOG2_N   (LOG2_N)
  ) u_acc (
    .clk       (clk),
    .rst       (reset),
    .clear     (w_clear),
    .enable    (w_accept),
    .sample    (in_data),
    .sample_sq (w_sq),
    .sum       (w_sum),
    .sumsq     (w_sumsq),
    .min_val   (w_min),
    .max_val   (w_max),
    .last      (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = ACCUM;
      ACCUM:   if (w_last) w_next = CALC1;
      CALC1:   w_next = CALC2;
      CALC2:   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mean <= '0;
      r_ex2  <= '0;
      r_var  <= '0;
      r_min  <= '0;
      r_max  <= '0;
    end else if (r_state == CALC1) begin
      r_mean <= IN_WIDTH'(w_sum >>> LOG2_N);
      r_ex2  <= PW'(w_sumsq >> LOG2_N);
      r_min  <= w_min;
      r_max  <= w_max;
    end else if (r_state == CALC2) begin
      // Floor rounding of both terms can make E[x^2] dip below mean^2.
      r_var <= (r_ex2 >= w_sq) ? (r_ex2 - w_sq) : '0;
    end
  end

  assign in_ready  = (r_state == ACCUM);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign mean      = r_mean;
  assign variance  = r_var;
  assign min_val   = r_min;
  assign max_val   = r_max;

endmodule
`default_nettype wire

// File: tb/tb_gaussian_stats_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_gaussian_stats_checker
// Brief   : Scoreboard bench for gaussian_stats_checker with a 4-sample window.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_gaussian_stats_checker;

  localparam int IN_WIDTH = 16;
  localparam int LOG2_N   = 2;

  logic clk = 1'b0;
  logic reset, start, in_valid, out_ready;
  logic signed [IN_WIDTH-1:0] in_data;
  logic in_ready, busy, out_valid;
  logic signed [IN_WIDTH-1:0] mean, min_val, max_val;
  logic [2*IN_WIDTH-1:0] variance;

  typedef struct {
    logic signed [15:0] m;
    logic [31:0]        v;
    logic signed [15:0] lo;
    logic signed [15:0] hi;
  } exp_t;

  exp_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;

  gaussian_stats_checker #(.IN_WIDTH(IN_WIDTH), .LOG2_N(LOG2_N)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .mean(mean), .variance(variance), .min_val(min_val), .max_val(max_val)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: floor-mean and clamped E[x^2]-mean^2 in wide integers.
  function automatic void push_model(input logic signed [15:0] a, b, c, d);
    logic signed [15:0] s[4];
    longint sum, sq, mu, ev;
    exp_t e;
    s = '{a, b, c, d};
    sum = 0; sq = 0;
    e.lo = s[0]; e.hi = s[0];
    for (int i = 0; i < 4; i++) begin
      sum += longint'(s[i]);
      sq  += longint'(s[i]) * longint'(s[i]);
      if (s[i] < e.lo) e.lo = s[i];
      if (s[i] > e.hi) e.hi = s[i];
    end
    mu = sum >>> 2;
    ev = (sq >>> 2) - mu * mu;
    if (ev < 0) ev = 0;
    e.m = 16'(mu);
    e.v = 32'(ev);
    sb.push_back(e);
  endfunction

  // Starts a window, feeds four samples with per-sample idle gaps (nibble i = gaps
  // before sample i), then waits for out_valid. lat counts cycles after the 4th accept.
  task automatic send_window(input logic signed [15:0] a, b, c, d, input logic [15:0] gaps,
                             input bit junk, output int lat, output logic rdy_after);
    logic signed [15:0] s[4];
    s = '{a, b, c, d};
    push_model(a, b, c, d);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < int'(gaps[4*i +: 4]); g++) begin
        in_valid = 1'b0; in_data = 16'sh7fff;
        @(negedge clk);
      end
      in_valid = 1'b1; in_data = s[i];
      @(negedge clk);
    end
    rdy_after = in_ready;
    in_valid = junk; in_data = 16'sh1234;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic ack(input bit with_start);
    @(negedge clk); out_ready = 1'b1; start = with_start;
    @(negedge clk); out_ready = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tests_run++; if ({busy, in_ready, out_valid} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b expected 000", {busy, in_ready, out_valid}); end
    tests_run++; if ({mean, variance, min_val, max_val} !== 80'd0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", {mean, variance, min_val, max_val}); end
    in_valid = 1'b1; in_data = 16'sd55; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    tests_run++; if ({busy, in_ready} !== 2'b00) begin tests_failed++; $display("FAIL idle_ignore: got %b expected 00", {busy, in_ready}); end
  endtask

  task automatic test_constant();
    exp_t e; int lat; logic rdy;
    send_window(100, 100, 100, 100, 16'h0000, 1'b0, lat, rdy);
    e = sb.pop_front();
    tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL const_latency: got %0d expected 3", lat); end
    tests_run++; if (mean !== e.m) begin tests_failed++; $display("FAIL const_mean: got %0d expected %0d", mean, e.m); end
    tests_run++; if (variance !== e.v) begin tests_failed++; $display("FAIL const_var: got %0d expected %0d", variance, e.v); end
    tests_run++; if ({min_val, max_val} !== {e.lo, e.hi}) begin tests_failed++; $display("FAIL const_minmax: got %0d/%0d expected %0d/%0d", min_val, max_val, e.lo, e.hi); end
    ack(1'b0);
    tests_run++; if ({out_valid, busy} !== 2'b00) begin tests_failed++; $display("FAIL const_ack: got %b expected 00", {out_valid, busy}); end
  endtask

  task automatic test_alternating();
    exp_t e; int lat; logic rdy;
    send_window(1000, -1000, 1000, -1000, 16'h0000, 1'b0, lat, rdy);
    e = sb.pop_front();
    tests_run++; if (mean !== e.m) begin tests_failed++; $display("FAIL alt_mean: got %0d expected %0d", mean, e.m); end
    tests_run++; if (variance !== e.v) begin tests_failed++; $display("FAIL alt_var: got %0d expected %0d", variance, e.v); end
    tests_run++; if ({min_val, max_val} !== {e.lo, e.hi}) begin tests_failed++; $display("FAIL alt_minmax: got %0d/%0d expected %0d/%0d", min_val, max_val, e.lo, e.hi); end
    ack(1'b0);
  endtask

  task automatic test_extremes();
    exp_t e; int lat; logic rdy;
    send_window(-32768, -32768, -32768, -32768, 16'h0000, 1'b0, lat, rdy);
    e = sb.pop_front();
    tests_run++; if (mean !== e.m) begin tests_failed++; $display("FAIL neg_mean: got %0d expected %0d", mean, e.m); end
    tests_run++; if (variance !== e.v) begin tests_failed++; $display("FAIL neg_var: got %0d expected %0d", variance, e.v); end
    ack(1'b0);
    send_window(1, 2, 3, 4, 16'h0000, 1'b0, lat, rdy);
    e = sb.pop_front();
    tests_run++; if (mean !== e.m) begin tests_failed++; $display("FAIL ramp_mean: got %0d expected %0d", mean, e.m); end
    tests_run++; if (variance !== e.v) begin tests_failed++; $display("FAIL ramp_var: got %0d expected %0d", variance, e.v); end
    tests_run++; if ({min_val, max_val} !== {e.lo, e.hi}) begin tests_failed++; $display("FAIL ramp_minmax: got %0d/%0d expected %0d/%0d", min_val, max_val, e.lo, e.hi); end
    ack(1'b0);
  endtask

  task automatic test_stall();
    exp_t e; int lat; logic rdy;
    // valid pattern 1,0,0,1,1,0,1 with junk valid held high after the window closes
    send_window(5, 6, 7, 8, 16'h1020, 1'b1, lat, rdy);
    e = sb.pop_front();
    tests_run++; if (rdy !== 1'b0) begin tests_failed++; $display("FAIL stall_ready: got %b expected 0", rdy); end
    tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL stall_latency: got %0d expected 3", lat); end
    tests_run++; if (mean !== e.m) begin tests_failed++; $display("FAIL stall_mean: got %0d expected %0d", mean, e.m); end
    tests_run++; if (variance !== e.v) begin tests_failed++; $display("FAIL stall_var: got %0d expected %0d", variance, e.v); end
    ack(1'b0);
  endtask

  task automatic test_hold_done();
    exp_t e; int lat; logic rdy; int bad;
    send_window(-3, 10, -20, 50, 16'h0000, 1'b0, lat, rdy);
    e = sb.pop_front();
    tests_run++; if ({mean, variance} !== {e.m, e.v}) begin tests_failed++; $display("FAIL hold_first: got %0d/%0d expected %0d/%0d", mean, variance, e.m, e.v); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      @(negedge clk);
      if (!out_valid || mean !== e.m || variance !== e.v || min_val !== e.lo || max_val !== e.hi) bad++;
    end
    start = 1'b0;
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
    ack(1'b1);
    tests_run++; if ({out_valid, busy} !== 2'b00) begin tests_failed++; $display("FAIL hold_ack_start: got %b expected 00", {out_valid, busy}); end
    tests_run++; if ({mean, min_val, max_val} !== {e.m, e.lo, e.hi}) begin tests_failed++; $display("FAIL hold_retain: got %0d expected %0d", mean, e.m); end
    send_window(9, 9, 9, 9, 16'h0000, 1'b0, lat, rdy);
    e = sb.pop_front();
    tests_run++; if ({out_valid, mean} !== {1'b1, e.m}) begin tests_failed++; $display("FAIL hold_next: got %b/%0d expected 1/%0d", out_valid, mean, e.m); end
    ack(1'b0);
  endtask

  task automatic test_mid_reset();
    exp_t e; int lat; logic rdy;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 16'sd300;
    @(negedge clk); in_data = -16'sd300;
    @(negedge clk); in_valid = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    tests_run++; if ({busy, in_ready, out_valid} !== 3'b000) begin tests_failed++; $display("FAIL midrst_flags: got %b expected 000", {busy, in_ready, out_valid}); end
    tests_run++; if ({mean, variance, min_val, max_val} !== 80'd0) begin tests_failed++; $display("FAIL midrst_data: got %h expected 0", {mean, variance, min_val, max_val}); end
    send_window(7, 7, 7, 7, 16'h0000, 1'b0, lat, rdy);
    e = sb.pop_front();
    tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL midrst_latency: got %0d expected 3", lat); end
    tests_run++; if ({mean, variance, min_val, max_val} !== {e.m, e.v, e.lo, e.hi}) begin tests_failed++; $display("FAIL midrst_window: got %0d/%0d expected %0d/%0d", mean, variance, e.m, e.v); end
    ack(1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_constant();
    test_alternating();
    test_extremes();
    test_stall();
    test_hold_done();
    test_mid_reset();
    tests_run++; if (sb.size() !== 0) begin tests_failed++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
